// File: rtl/ofmap_deaggregator.sv
// Drains ofmap accumulation-buffer entries and serializes each entry's lanes
// (lane 0 first) onto a one-word valid/ready stream.
module ofmap_deaggregator #(
    parameter int OFMAP_WIDTH           = 32,
    parameter int ARRAY_WIDTH           = 4,
    parameter int OFMAP_BANK_ADDR_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [OFMAP_BANK_ADDR_WIDTH-1:0]     ofmap_max_adr_c,
    input  logic                                 ofmap_db_empty_n,
    input  logic                                 ofmap_switch_banks,
    output logic                                 ofmap_wb_ren,
    output logic [OFMAP_BANK_ADDR_WIDTH-1:0]     ofmap_wb_adr,
    input  logic [ARRAY_WIDTH*OFMAP_WIDTH-1:0]   ofmap_wb_data,
    output logic [OFMAP_WIDTH-1:0]               ofmap_dout,
    output logic                                 ofmap_dout_vld,
    input  logic                                 ofmap_dout_rdy
);

    localparam int CW = $clog2(ARRAY_WIDTH);
    localparam int EW = ARRAY_WIDTH * OFMAP_WIDTH;

    logic [EW-1:0]          fifo_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             occ;
    logic                   in_flight;
    logic [CW-1:0]          lane_cnt;

    logic                   issue;
    logic                   capture;
    logic                   fire;
    logic                   last_lane;
    logic                   pop;
    logic [1:0]             occ_keep;
    logic [1:0]             occ_nxt;
    logic                   rd_ptr_nxt;
    logic [CW-1:0]          lane_nxt;
    logic [EW-1:0]          head_entry;
    logic                   vld_nxt;
    logic [OFMAP_WIDTH-1:0] dout_nxt;

    // The ren=0 term enforces a one-cycle gap so the lagging empty_n cannot cause an over-read.
    always_comb begin
        issue = ofmap_db_empty_n && !ofmap_wb_ren && !ofmap_switch_banks &&
                (({1'b0, occ} + {2'b00, in_flight}) < 3'd2);
    end

    always_comb begin
        capture    = in_flight;
        fire       = ofmap_dout_vld && ofmap_dout_rdy;
        last_lane  = (lane_cnt == CW'(ARRAY_WIDTH - 1));
        pop        = fire && last_lane;
        occ_keep   = occ - {1'b0, pop};
        occ_nxt    = occ_keep + {1'b0, capture};
        rd_ptr_nxt = rd_ptr ^ pop;
        lane_nxt   = lane_cnt;
        if (fire) begin
            lane_nxt = last_lane ? '0 : lane_cnt + 1'b1;
        end
    end

    // A capture into an otherwise empty FIFO becomes the head immediately, so bypass the storage.
    always_comb begin
        head_entry = fifo_mem[rd_ptr_nxt];
        if (capture && (occ_keep == 2'd0)) begin
            head_entry = ofmap_wb_data;
        end
        vld_nxt  = (occ_nxt != 2'd0);
        dout_nxt = ofmap_dout;
        if (vld_nxt) begin
            dout_nxt = head_entry[int'(lane_nxt)*OFMAP_WIDTH +: OFMAP_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ofmap_wb_ren <= 1'b0;
            ofmap_wb_adr <= '0;
            in_flight    <= 1'b0;
        end else begin
            ofmap_wb_ren <= issue;
            in_flight    <= ofmap_wb_ren;
            if (ofmap_switch_banks) begin
                ofmap_wb_adr <= '0;
            end else if (ofmap_wb_ren) begin
                ofmap_wb_adr <= (ofmap_wb_adr == ofmap_max_adr_c) ? '0 : ofmap_wb_adr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_mem[wr_ptr] <= ofmap_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            occ            <= 2'd0;
            lane_cnt       <= '0;
            ofmap_dout_vld <= 1'b0;
            ofmap_dout     <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= ~wr_ptr;
            end
            rd_ptr         <= rd_ptr_nxt;
            occ            <= occ_nxt;
            lane_cnt       <= lane_nxt;
            ofmap_dout_vld <= vld_nxt;
            ofmap_dout     <= dout_nxt;
        end
    end

endmodule

// File: tb/tb_ofmap_deaggregator.sv
// Directed bench for ofmap_deaggregator: behavioural controller count, bank memory and stream monitor.
module tb_ofmap_deaggregator;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    ofmap_max_adr_c;
    logic          ofmap_db_empty_n;
    logic          ofmap_switch_banks;
    logic          ofmap_wb_ren;
    logic [7:0]    ofmap_wb_adr;
    logic [127:0]  ofmap_wb_data;
    logic [31:0]   ofmap_dout;
    logic          ofmap_dout_vld;
    logic          ofmap_dout_rdy;

    int            loaded;
    int            taken;
    logic [3:0]    bank;
    logic [31:0]   out_q [$];
    logic [7:0]    ren_q [$];
    int            vecs  = 0;
    int            fails = 0;

    ofmap_deaggregator #(
        .OFMAP_WIDTH           (32),
        .ARRAY_WIDTH           (4),
        .OFMAP_BANK_ADDR_WIDTH (8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ofmap_max_adr_c    (ofmap_max_adr_c),
        .ofmap_db_empty_n   (ofmap_db_empty_n),
        .ofmap_switch_banks (ofmap_switch_banks),
        .ofmap_wb_ren       (ofmap_wb_ren),
        .ofmap_wb_adr       (ofmap_wb_adr),
        .ofmap_wb_data      (ofmap_wb_data),
        .ofmap_dout         (ofmap_dout),
        .ofmap_dout_vld     (ofmap_dout_vld),
        .ofmap_dout_rdy     (ofmap_dout_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [3:0] b, input logic [7:0] a, input int l);
        return {4'hA, b, a, 8'h5C, 8'(l)};
    endfunction

    // Controller: empty_n reflects the count after the previous edge's decrement.
    assign ofmap_db_empty_n = (loaded != taken);

    always @(posedge clk) begin
        if (!rst_n) taken <= 0;
        else if (ofmap_wb_ren) taken <= taken + 1;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            ofmap_wb_data[i*32 +: 32] <= ofmap_wb_ren ? word(bank, ofmap_wb_adr, i) : 32'hBAD0_BAD0;
        end
    end

    always @(negedge clk) begin
        if (ofmap_dout_vld && ofmap_dout_rdy) out_q.push_back(ofmap_dout);
        if (ofmap_wb_ren) ren_q.push_back(ofmap_wb_adr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_words(input int n);
        for (int k = 0; k < 400 && out_q.size() < n; k++) tick();
        chk("words_avail", 64'(out_q.size()), 64'(n));
    endtask

    task automatic do_reset();
        ofmap_dout_rdy     = 1'b0;
        ofmap_switch_banks = 1'b0;
        loaded             = 0;
        rst_n              = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        out_q.delete();
        ren_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        bank            = 4'h0;
        ofmap_max_adr_c = 8'd255;

        // Reset state
        do_reset();
        chk("rst_ren",  64'(ofmap_wb_ren),   64'd0);
        chk("rst_adr",  64'(ofmap_wb_adr),   64'd0);
        chk("rst_vld",  64'(ofmap_dout_vld), 64'd0);
        chk("rst_dout", 64'(ofmap_dout),     64'd0);

        // 1: three entries, free-running output
        bank = 4'h1; ofmap_dout_rdy = 1'b1; loaded = 3;
        tick();
        chk("t1_ren_c1", 64'(ofmap_wb_ren), 64'd1);
        chk("t1_adr_c1", 64'(ofmap_wb_adr), 64'd0);
        chk("t1_vld_c1", 64'(ofmap_dout_vld), 64'd0);
        tick();
        chk("t1_ren_c2", 64'(ofmap_wb_ren), 64'd0);
        chk("t1_adr_c2", 64'(ofmap_wb_adr), 64'd1);
        tick();
        chk("t1_ren_c3",  64'(ofmap_wb_ren), 64'd1);
        chk("t1_vld_c3",  64'(ofmap_dout_vld), 64'd1);
        chk("t1_dout_c3", 64'(ofmap_dout), 64'(word(4'h1, 8'd0, 0)));
        wait_words(12);
        for (int i = 0; i < 12; i++)
            chk("t1_word", 64'(out_q[i]), 64'(word(4'h1, 8'(i / 4), i % 4)));
        repeat (10) tick();
        chk("t1_ren_total", 64'(taken), 64'd3);
        chk("t1_ren_log",   64'(ren_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk("t1_ren_adr", 64'(ren_q[i]), 64'(i));
        chk("t1_idle_vld", 64'(ofmap_dout_vld), 64'd0);

        // 2: backpressure after the first word, then release
        out_q.delete(); ren_q.delete();
        bank = 4'h2; base = taken; loaded = loaded + 5;
        wait_words(1);
        ofmap_dout_rdy = 1'b0;
        tick();
        chk("t2_dout_stall0", 64'(ofmap_dout), 64'(word(4'h2, 8'd3, 1)));
        repeat (20) tick();
        chk("t2_ren_stalled", 64'(taken - base), 64'd2);
        chk("t2_vld_held",    64'(ofmap_dout_vld), 64'd1);
        chk("t2_dout_held",   64'(ofmap_dout), 64'(word(4'h2, 8'd3, 1)));
        chk("t2_no_xfer",     64'(out_q.size()), 64'd1);
        ofmap_dout_rdy = 1'b1;
        wait_words(20);
        for (int i = 0; i < 20; i++)
            chk("t2_word", 64'(out_q[i]), 64'(word(4'h2, 8'(3 + i / 4), i % 4)));
        repeat (5) tick();
        chk("t2_ren_total", 64'(taken - base), 64'd5);

        // 3: address wrap at max_adr=3
        do_reset();
        bank = 4'h3; ofmap_max_adr_c = 8'd3; ofmap_dout_rdy = 1'b1; loaded = 6;
        wait_words(24);
        for (int i = 0; i < 24; i++)
            chk("t3_word", 64'(out_q[i]), 64'(word(4'h3, 8'((i / 4) % 4), i % 4)));
        chk("t3_ren_log", 64'(ren_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) chk("t3_ren_adr", 64'(ren_q[i]), 64'(i % 4));

        // 4: bank switch with one entry buffered at adr=5
        do_reset();
        bank = 4'h4; ofmap_max_adr_c = 8'd255; ofmap_dout_rdy = 1'b1; loaded = 5;
        wait_words(16);
        chk("t4_adr_pre",  64'(ofmap_wb_adr), 64'd5);
        chk("t4_vld_pre",  64'(ofmap_dout_vld), 64'd1);
        chk("t4_dout_pre", 64'(ofmap_dout), 64'(word(4'h4, 8'd4, 0)));
        ofmap_switch_banks = 1'b1;
        tick();
        ofmap_switch_banks = 1'b0;
        chk("t4_adr_post", 64'(ofmap_wb_adr), 64'd0);
        bank = 4'h5; loaded = loaded + 2;
        wait_words(28);
        for (int i = 0; i < 4; i++)
            chk("t4_drain", 64'(out_q[16 + i]), 64'(word(4'h4, 8'd4, i)));
        for (int i = 0; i < 8; i++)
            chk("t4_newbank", 64'(out_q[20 + i]), 64'(word(4'h5, 8'(i / 4), i % 4)));
        chk("t4_ren_log", 64'(ren_q.size()), 64'd7);
        chk("t4_ren_adr5", 64'(ren_q[5]), 64'd0);
        chk("t4_ren_adr6", 64'(ren_q[6]), 64'd1);

        // 5: single entry, empty_n falls one cycle after the ren
        do_reset();
        bank = 4'h6; ofmap_dout_rdy = 1'b1; loaded = 1;
        repeat (12) tick();
        chk("t5_ren_total", 64'(taken), 64'd1);
        chk("t5_words",     64'(out_q.size()), 64'd4);

        // 6: reset mid-entry at lane 2
        do_reset();
        bank = 4'h8; ofmap_dout_rdy = 1'b1; loaded = 2;
        wait_words(2);
        chk("t6_dout_lane2", 64'(ofmap_dout), 64'(word(4'h8, 8'd0, 2)));
        rst_n = 1'b0; loaded = 0; ofmap_dout_rdy = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_vld_rst",  64'(ofmap_dout_vld), 64'd0);
        chk("t6_ren_rst",  64'(ofmap_wb_ren), 64'd0);
        chk("t6_dout_rst", 64'(ofmap_dout), 64'd0);
        chk("t6_adr_rst",  64'(ofmap_wb_adr), 64'd0);
        repeat (5) tick();
        chk("t6_vld_quiet", 64'(ofmap_dout_vld), 64'd0);
        out_q.delete(); ren_q.delete();
        bank = 4'h7; ofmap_dout_rdy = 1'b1; loaded = 1;
        wait_words(4);
        for (int i = 0; i < 4; i++)
            chk("t6_restart", 64'(out_q[i]), 64'(word(4'h7, 8'd0, i)));
        chk("t6_ren_adr", 64'(ren_q[0]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
